// File: rtl/bnn_conv_engine.sv
// Streaming binary-weight K x K convolution engine.
// One signed feature map enters row-major over valid/ready. NCH +/-1 kernels
// are applied in parallel, and one NCH-channel result leaves per valid pixel.
// Handshake: a beat transfers on any rising edge where valid && ready.
// Producers hold valid and data stable until the beat transfers.
// din_ready is combinational on out_ready because a single output register
// sits between the datapath and the consumer.
module bnn_conv_engine #(
   parameter  int IMG_W = 28,
   parameter  int K     = 5,
   parameter  int NCH   = 6,
   parameter  int DW    = 32,
   localparam int ACC_W = DW + $clog2(K*K)
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic                    binarize,
   input  logic                    w_we,
   input  logic [$clog2(NCH)-1:0]  w_ch,
   input  logic [K*K-1:0]          w_data,
   input  logic signed [DW-1:0]    din,
   input  logic                    din_valid,
   output logic                    din_ready,
   output logic [NCH*ACC_W-1:0]    dout,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    done
);

   localparam int OUT_W = IMG_W - K + 1;
   localparam int CW    = $clog2(IMG_W);
   localparam int CH_W  = $clog2(NCH);
   localparam int LB_N  = (K-1) * IMG_W;
   localparam logic [CW-1:0] LAST      = CW'(IMG_W - 1);
   localparam logic [CW-1:0] FIRST_OUT = CW'(IMG_W - OUT_W);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nx;

   logic [K*K-1:0]          wt [NCH];
   logic [CW-1:0]           row, col;
   logic                    bin_q;
   logic signed [DW-1:0]    lb [LB_N];
   logic signed [DW-1:0]    win [K][K];
   logic signed [DW-1:0]    win_nx [K][K];
   logic signed [ACC_W-1:0] acc, xe;
   logic [NCH*ACC_W-1:0]    res;
   logic                    accept, last_pix, produce, out_fire;

   assign accept   = din_valid && din_ready;
   assign last_pix = (row == LAST) && (col == LAST);
   assign produce  = accept && (row >= FIRST_OUT) && (col >= FIRST_OUT);
   assign out_fire = out_valid && out_ready;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state: a frame ends once the last output leaves the output register
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (accept && last_pix) state_nx = DRAIN;
         DRAIN:   if (out_fire) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs: input accepted only while the output stage can take a result
   always_comb begin
      busy      = (state == RUN) || (state == DRAIN);
      din_ready = (state == RUN) && (!out_valid || out_ready);
   end

   // Frame control: pixel position, latched mode and the done pulse
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         row   <= '0;
         col   <= '0;
         bin_q <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= (state == DRAIN) && out_fire;
         if (state == IDLE && start) begin
            row   <= '0;
            col   <= '0;
            bin_q <= binarize;
         end else if (accept) begin
            if (col == LAST) begin
               col <= '0;
               row <= (row == LAST) ? '0 : row + CW'(1);
            end else begin
               col <= col + CW'(1);
            end
         end
      end
   end

   // Kernel store; writes are honoured only between frames
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int c = 0; c < NCH; c++) wt[c] <= '0;
      end else if (w_we && state == IDLE) begin
         for (int c = 0; c < NCH; c++)
            if (w_ch == CH_W'(c)) wt[c] <= w_data;
      end
   end

   // Line buffer and window advance per accepted beat; contents are never reset
   always_ff @(posedge clk) begin
      if (accept) begin
         lb[0] <= din;
         for (int i = 1; i < LB_N; i++) lb[i] <= lb[i-1];
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) win[i][j] <= win_nx[i][j];
      end
   end

   // Window after this beat: shift left, new right column from line buffer + din
   always_comb begin
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K-1; j++) win_nx[i][j] = win[i][j+1];
      for (int i = 0; i < K-1; i++) win_nx[i][K-1] = lb[(K-1-i)*IMG_W - 1];
      win_nx[K-1][K-1] = din;
   end

   // Per-channel signed +/-1 dot product, optionally reduced to its sign bit
   always_comb begin
      res = '0;
      acc = '0;
      xe  = '0;
      for (int c = 0; c < NCH; c++) begin
         acc = '0;
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
               xe = ACC_W'(win_nx[i][j]);
               if (wt[c][i*K+j]) acc = acc + xe;
               else              acc = acc - xe;
            end
         end
         res[c*ACC_W +: ACC_W] = bin_q ? {{(ACC_W-1){1'b0}}, ~acc[ACC_W-1]} : acc;
      end
   end

   // Single output stage: load on a producing beat, clear when drained
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         dout      <= '0;
      end else if (produce) begin
         out_valid <= 1'b1;
         dout      <= res;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bnn_conv_engine.sv
// Directed bench for bnn_conv_engine: constant, ramp and random frames,
// back-pressure, ignored mid-frame commands, mid-frame reset and a
// single-output frame on a minimal instance.
`timescale 1ns/1ps
module tb_bnn_conv_engine;

   localparam int IMG_W = 28;
   localparam int K     = 5;
   localparam int NCH   = 6;
   localparam int DW    = 32;
   localparam int ACC_W = DW + $clog2(K*K);
   localparam int NPIX  = IMG_W * IMG_W;
   localparam int OW    = IMG_W - K + 1;
   localparam int MAXC  = 5000;

   typedef logic [NCH*ACC_W-1:0] vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // main instance
   logic                   start = 1'b0, binarize = 1'b0, w_we = 1'b0;
   logic [$clog2(NCH)-1:0] w_ch = '0;
   logic [K*K-1:0]         w_data = '0;
   logic signed [DW-1:0]   din = '0;
   logic                   din_valid = 1'b0, din_ready;
   vec_t                   dout;
   logic                   out_valid, out_ready = 1'b1, busy, done;

   bnn_conv_engine #(.IMG_W(IMG_W), .K(K), .NCH(NCH), .DW(DW)) u_dut (
      .clk(clk), .rstn(rstn), .start(start), .binarize(binarize),
      .w_we(w_we), .w_ch(w_ch), .w_data(w_data),
      .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   // minimal instance: 3x3 map, 3x3 kernel, 2 channels, 8-bit samples
   logic              s_start = 1'b0, s_binarize = 1'b0, s_w_we = 1'b0;
   logic [0:0]        s_w_ch = '0;
   logic [8:0]        s_w_data = '0;
   logic signed [7:0] s_din = '0;
   logic              s_din_valid = 1'b0, s_din_ready;
   logic [23:0]       s_dout;
   logic              s_out_valid, s_out_ready = 1'b1, s_busy, s_done;

   bnn_conv_engine #(.IMG_W(3), .K(3), .NCH(2), .DW(8)) u_small (
      .clk(clk), .rstn(rstn), .start(s_start), .binarize(s_binarize),
      .w_we(s_w_we), .w_ch(s_w_ch), .w_data(s_w_data),
      .din(s_din), .din_valid(s_din_valid), .din_ready(s_din_ready),
      .dout(s_dout), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .busy(s_busy), .done(s_done)
   );

   // ---------------- scoreboard state ----------------
   int                   n_vec = 0;
   int                   n_fail = 0;
   vec_t                 exp_q[$];
   logic signed [DW-1:0] img [IMG_W][IMG_W];
   logic [K*K-1:0]       wt [NCH];

   task automatic chk(input string tag, input vec_t obs, input vec_t exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_w(input int c, input logic [K*K-1:0] data);
      w_ch   = c[$clog2(NCH)-1:0];
      w_data = data;
      w_we   = 1'b1;
      @(posedge clk); #1;
      w_we   = 1'b0;
      wt[c]  = data;
   endtask

   task automatic fill_img(input int mode, input int val);
      for (int r = 0; r < IMG_W; r++)
         for (int c = 0; c < IMG_W; c++)
            case (mode)
               0:       img[r][c] = DW'(val);
               1:       img[r][c] = DW'(r*IMG_W + c);
               default: img[r][c] = $urandom();
            endcase
   endtask

   task automatic fill_const(input vec_t v);
      exp_q.delete();
      for (int n = 0; n < OW*OW; n++) exp_q.push_back(v);
   endtask

   // Reference convolution straight from the kernel-bit definition
   task automatic build_exp(input bit bin);
      vec_t   v;
      longint s, px;
      exp_q.delete();
      for (int r = K-1; r < IMG_W; r++) begin
         for (int c = K-1; c < IMG_W; c++) begin
            v = '0;
            for (int ch = 0; ch < NCH; ch++) begin
               s = 0;
               for (int i = 0; i < K; i++)
                  for (int j = 0; j < K; j++) begin
                     px = img[r-K+1+i][c-K+1+j];
                     s  = wt[ch][i*K+j] ? s + px : s - px;
                  end
               v[ch*ACC_W +: ACC_W] = bin ? ACC_W'((s >= 0) ? 1 : 0) : ACC_W'(s);
            end
            exp_q.push_back(v);
         end
      end
   endtask

   // Streams one frame; rnd adds valid gaps and random out_ready,
   // inject issues start/w_we mid-frame, abort_at >= 0 stops after that many beats.
   task automatic run_frame(input bit bin, input bit rnd, input bit inject, input int abort_at);
      int pix = 0;
      int cyc = 0;
      start    = 1'b1;
      binarize = bin;
      @(posedge clk); #1;
      start    = 1'b0;
      chk("busy_rise", vec_t'(busy), vec_t'(1));
      while ((pix < NPIX || exp_q.size() > 0) && cyc < MAXC &&
             !(abort_at >= 0 && pix == abort_at)) begin
         din_valid = (pix < NPIX) && (!rnd || $urandom_range(0, 3) != 0);
         din       = (pix < NPIX) ? img[pix / IMG_W][pix % IMG_W] : '0;
         out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (inject && cyc == 150) begin
            start    = 1'b1;
            binarize = !bin;
            w_we     = 1'b1;
            w_ch     = '0;
            w_data   = ~wt[0];
         end else begin
            start = 1'b0;
            w_we  = 1'b0;
         end
         @(negedge clk);
         chk("din_ready", vec_t'(din_ready), vec_t'((pix < NPIX) && !(out_valid && !out_ready)));
         chk("busy_run", vec_t'(busy), vec_t'(1));
         chk("done_low", vec_t'(done), vec_t'(0));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_output", vec_t'(out_valid), vec_t'(0));
            else                   chk("dout", dout, exp_q.pop_front());
         end
         if (din_valid && din_ready) pix++;
         @(posedge clk); #1;
         cyc++;
      end
      din_valid = 1'b0;
      out_ready = 1'b1;
      start     = 1'b0;
      w_we      = 1'b0;
      if (abort_at < 0) begin
         chk("pixels_accepted", vec_t'(pix), vec_t'(NPIX));
         chk("outputs_missing", vec_t'(exp_q.size()), vec_t'(0));
         chk("done_pulse", vec_t'(done), vec_t'(1));
         chk("busy_fall", vec_t'(busy), vec_t'(0));
         @(posedge clk); #1;
         chk("done_clear", vec_t'(done), vec_t'(0));
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      vec_t v;
      int   s_pix, s_nout, s_ndone;

      for (int c = 0; c < NCH; c++) wt[c] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_din_ready", vec_t'(din_ready), vec_t'(0));
      chk("rst_out_valid", vec_t'(out_valid), vec_t'(0));
      chk("rst_dout", dout, vec_t'(0));
      chk("rst_done", vec_t'(done), vec_t'(0));
      chk("rst_busy", vec_t'(busy), vec_t'(0));
      rstn = 1'b1;
      @(posedge clk); #1;

      // all +1 kernels over a map of ones: every channel sums to 25
      for (int c = 0; c < NCH; c++) load_w(c, '1);
      fill_img(0, 1);
      fill_const({NCH{ACC_W'(25)}});
      run_frame(1'b0, 1'b0, 1'b0, -1);

      // ch0 all +1, others all -1 over constant -3: ch0 = -75, others +75
      for (int c = 1; c < NCH; c++) load_w(c, '0);
      fill_img(0, -3);
      v = {NCH{ACC_W'(75)}};
      v[0 +: ACC_W] = ACC_W'(-75);
      fill_const(v);
      run_frame(1'b0, 1'b0, 1'b0, -1);

      // same frame binarized: ch0 = 0, others 1
      v = {NCH{ACC_W'(1)}};
      v[0 +: ACC_W] = '0;
      fill_const(v);
      run_frame(1'b1, 1'b0, 1'b0, -1);

      // zero map binarized: every sum is 0, which maps to 1
      fill_img(0, 0);
      fill_const({NCH{ACC_W'(1)}});
      run_frame(1'b1, 1'b0, 1'b0, -1);

      // ramp, ch0 has only its top-left tap at +1
      load_w(0, 25'h1);
      fill_img(1, 0);
      build_exp(1'b0);
      run_frame(1'b0, 1'b0, 1'b0, -1);

      // same ramp under random back-pressure and valid gaps
      build_exp(1'b0);
      run_frame(1'b0, 1'b1, 1'b0, -1);

      // start / w_we / binarize toggled mid-frame must be ignored
      build_exp(1'b0);
      run_frame(1'b0, 1'b1, 1'b1, -1);

      // random weights and samples, binarized
      for (int c = 0; c < NCH; c++) load_w(c, 25'($urandom()));
      fill_img(2, 0);
      build_exp(1'b1);
      run_frame(1'b1, 1'b0, 1'b0, -1);

      // reset at pixel 400 aborts the frame and clears weights
      build_exp(1'b0);
      run_frame(1'b0, 1'b0, 1'b0, 400);
      rstn = 1'b0;
      #1;
      chk("abort_out_valid", vec_t'(out_valid), vec_t'(0));
      chk("abort_dout", dout, vec_t'(0));
      chk("abort_din_ready", vec_t'(din_ready), vec_t'(0));
      chk("abort_busy", vec_t'(busy), vec_t'(0));
      chk("abort_done", vec_t'(done), vec_t'(0));
      @(posedge clk); #1;
      chk("abort_hold", dout, vec_t'(0));
      rstn = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) wt[c] = '0;
      build_exp(1'b0);
      run_frame(1'b0, 1'b0, 1'b0, -1);

      // reload and fresh frame after the abort
      for (int c = 0; c < NCH; c++) load_w(c, 25'($urandom()));
      fill_img(2, 0);
      build_exp(1'b0);
      run_frame(1'b0, 1'b1, 1'b0, -1);

      // map width equal to kernel: exactly one output, ch0 = 1+..+9, ch1 = -45
      s_w_we = 1'b1; s_w_ch = 1'b0; s_w_data = 9'h1FF;
      @(posedge clk); #1;
      s_w_ch = 1'b1; s_w_data = 9'h000;
      @(posedge clk); #1;
      s_w_we = 1'b0; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      s_pix = 0; s_nout = 0; s_ndone = 0;
      for (int n = 0; n < 20; n++) begin
         s_din_valid = (s_pix < 9);
         s_din       = 8'(s_pix + 1);
         @(negedge clk);
         if (s_done) s_ndone++;
         if (s_out_valid && s_out_ready) begin
            s_nout++;
            chk("small_dout", vec_t'(s_dout), vec_t'({12'(-45), 12'(45)}));
         end
         if (s_din_valid && s_din_ready) s_pix++;
         @(posedge clk); #1;
      end
      s_din_valid = 1'b0;
      chk("small_out_count", vec_t'(s_nout), vec_t'(1));
      chk("small_done_count", vec_t'(s_ndone), vec_t'(1));
      chk("small_busy_idle", vec_t'(s_busy), vec_t'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
